conv_sequencer: RTL and testbench
=================================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 SHALL have parameter INW, default 16, MAC operand width.
REQ-002 SHALL have parameter OUTW, default 64, MAC accumulator/result width.
REQ-003 SHALL have parameter DIMW, default 8, width of dimension inputs N and K.
REQ-004 SHALL have parameter XAW, default 16, input-memory address width.
REQ-005 SHALL have parameter WAW, default 8, kernel-memory address width.
REQ-006 SHALL have ports, with clock and reset first:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  pulse that begins a convolution.
- n_dim  in  DIMW  input matrix is n_dim x n_dim.
- k_dim  in  DIMW  kernel is k_dim x k_dim.
- bias  in  INW  signed accumulator initial value.
- x_addr  out  XAW  input SRAM read address.
- x_data  in  INW  input SRAM read data, 1-cycle latency.
- w_addr  out  WAW  kernel SRAM read address.
- w_data  in  INW  kernel SRAM read data, 1-cycle latency.
- mac_in0, mac_in1  out  INW  MAC operands (x, w).
- mac_init_value  out  INW  MAC initial value (= latched bias).
- mac_init_acc  out  1  MAC accumulator load.
- mac_valid  out  1  MAC accumulate enable.
- mac_out  in  OUTW  registered MAC accumulator.
- y_data  out  OUTW  output pixel.
- y_valid  out  1  output pixel valid.
- y_ready  in  1  downstream accept.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky bad-dimension flag, cleared on next accepted start.

Function
REQ-007 SHALL latch n_dim, k_dim and bias on an accepted start (start=1 in IDLE); start at any other time SHALL be ignored.
REQ-008 SHALL, if latched k_dim=0, n_dim=0 or k_dim>n_dim, set err, pulse done the next cycle, and return to IDLE with no MAC or y activity.
REQ-009 SHALL produce M*M outputs, M=n_dim-k_dim+1, in row-major order over output indices (i,j).
REQ-010 SHALL use FSM states IDLE -> INIT -> ISSUE -> DRAIN -> OUTPUT, then back to INIT for the next pixel, or to DONE -> IDLE after the last pixel.
REQ-011 INIT SHALL last 1 cycle, assert mac_init_acc, and hold mac_valid=0.
REQ-012 ISSUE SHALL last exactly k_dim*k_dim cycles, each cycle presenting x_addr=(i+p)*n_dim+(j+q) and w_addr=p*k_dim+q, with q innermost.
REQ-013 mac_valid SHALL equal the ISSUE strobe delayed one cycle, so that mac_in0=x_data and mac_in1=w_data are valid in the cycle mac_valid=1.
REQ-014 DRAIN SHALL last 2 cycles, covering the last data return and the MAC register update.
REQ-015 OUTPUT SHALL register y_data=mac_out and assert y_valid.
REQ-016 While y_valid=1 and y_ready=0, y_data SHALL hold stable.
REQ-017 The transfer SHALL occur on the cycle y_valid=1 and y_ready=1, after which y_valid SHALL drop.
REQ-018 Per-pixel latency from the INIT cycle to the first y_valid cycle SHALL be k_dim*k_dim+3 cycles.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 done SHALL pulse for exactly 1 cycle in DONE.
REQ-021 Address arithmetic SHALL be unsigned and truncated to XAW/WAW; callers guarantee n_dim*n_dim <= 2^XAW and k_dim*k_dim <= 2^WAW.

Reset
REQ-022 reset SHALL, at any state including mid-ISSUE or mid-OUTPUT, force IDLE and clear these outputs to 0: x_addr, w_addr, mac_in0, mac_in1, mac_init_value, mac_init_acc, mac_valid, y_data, y_valid, busy, done, err.
REQ-023 reset SHALL take priority over start.

Structure
REQ-024 The FSM state enum and the DRAIN_CYCLES=2 constant SHALL reside in shared package conv_pkg.
REQ-025 The nested i/j/p/q counters and address computation SHALL be one sub-module, conv_addr_gen.
REQ-026 The MAC SHALL be external to this module.

Verification
REQ-027 n_dim=3, k_dim=2, bias=0, X=1..9, W=[1,0;0,1], y_ready=1 -> y_data sequence 6,8,12,14, then done.
REQ-028 n_dim=2, k_dim=2, bias=5, X=W=all 2, y_ready=1 -> single y_data=21, 7 cycles from INIT to y_valid.
REQ-029 k_dim=4, n_dim=3 -> err=1, done pulse 1 cycle after start, mac_valid and y_valid never asserted.
REQ-030 As REQ-027 but y_ready held low 5 cycles on the first pixel -> y_data=6 stable for all 5 cycles, no pixel lost, sequence unchanged.
REQ-031 reset asserted mid-ISSUE of pixel 2, then a new start -> all outputs 0 the cycle after reset, and the rerun output matches REQ-027 exactly.
REQ-032 start pulsed while busy -> ignored, results unchanged, exactly one done pulse.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sequencer.
package conv_pkg;

  // Sequencer states. One pass per output pixel is INIT -> ISSUE -> DRAIN -> OUTPUT.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUTPUT = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // One cycle for the last SRAM read to return, one for the MAC register update.
  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_CNT_W  = $clog2(DRAIN_CYCLES + 1);

  // A zero-sized input or kernel, or a kernel larger than the input, yields no pixels.
  function automatic logic dims_bad(input logic [31:0] n, input logic [31:0] k);
    return (n == 32'd0) || (k == 32'd0) || (k > n);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Nested pixel (i,j) and tap (p,q) counters plus SRAM address arithmetic.
// The counters hold the tap presented in the current cycle; addresses are
// derived from them, so a tap step takes effect on the next cycle.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int DIMW = 8,
  parameter int XAW  = 16,
  parameter int WAW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [DIMW-1:0] n_dim,
  input  logic [DIMW-1:0] k_dim,
  input  logic            step,
  input  logic            advance,
  output logic [XAW-1:0]  x_addr,
  output logic [WAW-1:0]  w_addr,
  output logic            last_tap,
  output logic            last_pixel
);

  logic [DIMW-1:0] n_q, n_d;
  logic [DIMW-1:0] k_q, k_d;
  logic [DIMW-1:0] m_q, m_d;
  logic [DIMW-1:0] i_q, i_d;
  logic [DIMW-1:0] j_q, j_d;
  logic [DIMW-1:0] p_q, p_d;
  logic [DIMW-1:0] q_q, q_d;

  logic [XAW-1:0] x_row;
  logic [XAW-1:0] x_col;

  assign last_tap   = (p_q == k_q - DIMW'(1)) && (q_q == k_q - DIMW'(1));
  assign last_pixel = (i_q == m_q - DIMW'(1)) && (j_q == m_q - DIMW'(1));

  // Address arithmetic is unsigned and wraps at the address width.
  always_comb begin
    x_row  = XAW'(i_q) + XAW'(p_q);
    x_col  = XAW'(j_q) + XAW'(q_q);
    x_addr = x_row * XAW'(n_q) + x_col;
    w_addr = WAW'(p_q) * WAW'(k_q) + WAW'(q_q);
  end

  // Next-state for dimensions and counters: q innermost within a pixel, j innermost across pixels.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned, which would infer a latch.
    n_d = n_q;
    k_d = k_q;
    m_d = m_q;
    i_d = i_q;
    j_d = j_q;
    p_d = p_q;
    q_d = q_q;
    if (load) begin
      n_d = n_dim;
      k_d = k_dim;
      m_d = n_dim - k_dim + DIMW'(1);
      i_d = '0;
      j_d = '0;
      p_d = '0;
      q_d = '0;
    end else begin
      if (step) begin
        if (q_q == k_q - DIMW'(1)) begin
          q_d = '0;
          p_d = (p_q == k_q - DIMW'(1)) ? '0 : p_q + DIMW'(1);
        end else begin
          q_d = q_q + DIMW'(1);
        end
      end
      if (advance) begin
        if (j_q == m_q - DIMW'(1)) begin
          j_d = '0;
          i_d = (i_q == m_q - DIMW'(1)) ? '0 : i_q + DIMW'(1);
        end else begin
          j_d = j_q + DIMW'(1);
        end
      end
    end
  end

  // Counter and dimension registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      n_q <= '0;
      k_q <= '0;
      m_q <= '0;
      i_q <= '0;
      j_q <= '0;
      p_q <= '0;
      q_q <= '0;
    end else begin
      n_q <= n_d;
      k_q <= k_d;
      m_q <= m_d;
      i_q <= i_d;
      j_q <= j_d;
      p_q <= p_d;
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution sequencer: walks every output pixel of an n x n input with a
// k x k kernel, streams operand pairs to an external MAC and hands each
// finished pixel downstream over a valid/ready port.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int INW  = 16,
  parameter int OUTW = 64,
  parameter int DIMW = 8,
  parameter int XAW  = 16,
  parameter int WAW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DIMW-1:0] n_dim,
  input  logic [DIMW-1:0] k_dim,
  input  logic [INW-1:0]  bias,
  output logic [XAW-1:0]  x_addr,
  input  logic [INW-1:0]  x_data,
  output logic [WAW-1:0]  w_addr,
  input  logic [INW-1:0]  w_data,
  output logic [INW-1:0]  mac_in0,
  output logic [INW-1:0]  mac_in1,
  output logic [INW-1:0]  mac_init_value,
  output logic            mac_init_acc,
  output logic            mac_valid,
  input  logic [OUTW-1:0] mac_out,
  output logic [OUTW-1:0] y_data,
  output logic            y_valid,
  input  logic            y_ready,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e                 state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [INW-1:0]         init_value_q, init_value_d;
  logic                   init_acc_q, init_acc_d;
  logic                   mac_valid_q, mac_valid_d;
  logic [OUTW-1:0]        y_data_q, y_data_d;
  logic                   y_valid_q, y_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic ag_load;
  logic ag_step;
  logic ag_advance;
  logic last_tap;
  logic last_pixel;

  conv_addr_gen #(
    .DIMW (DIMW),
    .XAW  (XAW),
    .WAW  (WAW)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (ag_load),
    .n_dim      (n_dim),
    .k_dim      (k_dim),
    .step       (ag_step),
    .advance    (ag_advance),
    .x_addr     (x_addr),
    .w_addr     (w_addr),
    .last_tap   (last_tap),
    .last_pixel (last_pixel)
  );

  // SRAM data returns in the cycle after ISSUE; gating keeps the operands at zero when idle.
  assign mac_in0        = mac_valid_q ? x_data : '0;
  assign mac_in1        = mac_valid_q ? w_data : '0;
  assign mac_init_value = init_value_q;
  assign mac_init_acc   = init_acc_q;
  assign mac_valid      = mac_valid_q;
  assign y_data         = y_data_q;
  assign y_valid        = y_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

  // FSM next state and the registered outputs for the state being entered.
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    init_value_d = init_value_q;
    init_acc_d   = 1'b0;
    mac_valid_d  = (state_q == ST_ISSUE);
    y_data_d     = y_data_q;
    y_valid_d    = y_valid_q;
    done_d       = 1'b0;
    err_d        = err_q;
    ag_load      = 1'b0;
    ag_step      = 1'b0;
    ag_advance   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ag_load      = 1'b1;
          init_value_d = bias;
          if (dims_bad(32'(n_dim), 32'(k_dim))) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d      = 1'b0;
            init_acc_d = 1'b1;
            state_d    = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        ag_step = 1'b1;
        if (last_tap) begin
          drain_cnt_d = '0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
        if (drain_cnt_q == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) begin
          y_data_d  = mac_out;
          y_valid_d = 1'b1;
          state_d   = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        // y_data is held untouched until the downstream side accepts it.
        if (y_ready) begin
          y_valid_d  = 1'b0;
          ag_advance = 1'b1;
          if (last_pixel) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            init_acc_d = 1'b1;
            state_d    = ST_INIT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      drain_cnt_q  <= '0;
      init_value_q <= '0;
      init_acc_q   <= 1'b0;
      mac_valid_q  <= 1'b0;
      y_data_q     <= '0;
      y_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      init_value_q <= init_value_d;
      init_acc_q   <= init_acc_d;
      mac_valid_q  <= mac_valid_d;
      y_data_q     <= y_data_d;
      y_valid_q    <= y_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with SRAM and MAC models around it.
module tb_conv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  n_dim = '0;
  logic [7:0]  k_dim = '0;
  logic [15:0] bias = '0;
  logic [15:0] x_addr;
  logic [15:0] x_data = '0;
  logic [7:0]  w_addr;
  logic [15:0] w_data = '0;
  logic [15:0] mac_in0;
  logic [15:0] mac_in1;
  logic [15:0] mac_init_value;
  logic        mac_init_acc;
  logic        mac_valid;
  logic [63:0] mac_out = '0;
  logic [63:0] y_data;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [15:0] xmem [256];
  logic [15:0] wmem [256];

  logic [63:0] ys[$];
  int done_cnt = 0;
  int mv_cnt = 0;
  int yv_cnt = 0;
  int init_cnt = 0;
  int cyc = 0;
  int init_cyc = 0;
  int lat = -1;
  logic yv_prev = 1'b0;

  conv_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .n_dim          (n_dim),
    .k_dim          (k_dim),
    .bias           (bias),
    .x_addr         (x_addr),
    .x_data         (x_data),
    .w_addr         (w_addr),
    .w_data         (w_data),
    .mac_in0        (mac_in0),
    .mac_in1        (mac_in1),
    .mac_init_value (mac_init_value),
    .mac_init_acc   (mac_init_acc),
    .mac_valid      (mac_valid),
    .mac_out        (mac_out),
    .y_data         (y_data),
    .y_valid        (y_valid),
    .y_ready        (y_ready),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  // SRAMs with one-cycle read latency.
  always @(posedge clk) begin
    x_data <= xmem[x_addr[7:0]];
    w_data <= wmem[w_addr[7:0]];
  end

  // External signed MAC with a registered accumulator.
  always @(posedge clk) begin
    if (mac_init_acc)
      mac_out <= 64'(longint'($signed(mac_init_value)));
    else if (mac_valid)
      mac_out <= mac_out + 64'(longint'($signed(mac_in0)) * longint'($signed(mac_in1)));
  end

  // Monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (y_valid && y_ready) ys.push_back(y_data);
      if (done) done_cnt++;
      if (mac_valid) mv_cnt++;
      if (y_valid) yv_cnt++;
      if (mac_init_acc) begin
        init_cyc = cyc;
        init_cnt++;
      end
      if (y_valid && !yv_prev && lat < 0) lat = cyc - init_cyc;
      yv_prev = y_valid;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    ys.delete();
    done_cnt = 0;
    mv_cnt = 0;
    yv_cnt = 0;
    init_cnt = 0;
    lat = -1;
  endtask

  // X = 1..9 row-major, W = [1,0;0,1].
  task automatic load_a();
    for (int a = 0; a < 256; a++) begin
      xmem[a] = 16'(a + 1);
      wmem[a] = '0;
    end
    wmem[0] = 16'd1;
    wmem[3] = 16'd1;
  endtask

  task automatic load_twos();
    for (int a = 0; a < 256; a++) begin
      xmem[a] = 16'd2;
      wmem[a] = 16'd2;
    end
  endtask

  task automatic start_conv(input int n, input int k, input int b);
    @(posedge clk); #1;
    n_dim = 8'(n);
    k_dim = 8'(k);
    bias = 16'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_seq_a(input string tag);
    logic [63:0] exp [4];
    exp[0] = 64'd6;
    exp[1] = 64'd8;
    exp[2] = 64'd12;
    exp[3] = 64'd14;
    check({tag, "_count"}, 64'(ys.size()), 64'd4);
    for (int e = 0; e < 4; e++)
      check($sformatf("%s_y%0d", tag, e), (e < ys.size()) ? ys[e] : 64'hDEAD, exp[e]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x_addr"}, 64'(x_addr), 64'd0);
    check({tag, "_w_addr"}, 64'(w_addr), 64'd0);
    check({tag, "_mac_in"}, 64'({mac_in0, mac_in1}), 64'd0);
    check({tag, "_init_value"}, 64'(mac_init_value), 64'd0);
    check({tag, "_ctl"}, 64'({mac_init_acc, mac_valid, y_valid, busy, done, err}), 64'd0);
    check({tag, "_y_data"}, y_data, 64'd0);
  endtask

  initial begin
    int c;
    load_a();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Basic 3x3 input, 2x2 kernel.
    clear_mon();
    start_conv(3, 2, 0);
    check("basic_busy", 64'(busy), 64'd1);
    wait_done(400);
    check_seq_a("basic");
    check("basic_done_cnt", 64'(done_cnt), 64'd1);
    check("basic_err", 64'(err), 64'd0);
    check("basic_busy_end", 64'(busy), 64'd0);
    check("basic_mac_valid_cycles", 64'(mv_cnt), 64'd16);
    check("basic_y_valid_cycles", 64'(yv_cnt), 64'd4);

    // Single pixel with bias, latency from INIT to y_valid.
    load_twos();
    clear_mon();
    start_conv(2, 2, 5);
    wait_done(400);
    check("bias_count", 64'(ys.size()), 64'd1);
    check("bias_y", (ys.size() > 0) ? ys[0] : 64'hDEAD, 64'd21);
    check("bias_latency", 64'(lat), 64'd7);

    // Kernel larger than input.
    clear_mon();
    start_conv(3, 4, 0);
    check("err_done_pulse", 64'(done), 64'd1);
    check("err_flag", 64'(err), 64'd1);
    @(posedge clk); #1;
    check("err_done_drop", 64'(done), 64'd0);
    check("err_idle", 64'(busy), 64'd0);
    check("err_sticky", 64'(err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("err_no_mac", 64'(mv_cnt), 64'd0);
    check("err_no_y", 64'(yv_cnt), 64'd0);
    check("err_done_cnt", 64'(done_cnt), 64'd1);

    // Backpressure on the first pixel.
    load_a();
    clear_mon();
    y_ready = 1'b0;
    start_conv(3, 2, 0);
    check("stall_err_cleared", 64'(err), 64'd0);
    c = 0;
    @(negedge clk);
    while (!y_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("stall_y_valid_seen", 64'(y_valid), 64'd1);
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      check($sformatf("stall_hold%0d", s), {y_data[62:0], y_valid}, {63'd6, 1'b1});
    end
    @(posedge clk); #1;
    y_ready = 1'b1;
    wait_done(400);
    check_seq_a("stall");
    check("stall_done_cnt", 64'(done_cnt), 64'd1);

    // Reset in the middle of ISSUE for pixel 2, then rerun.
    clear_mon();
    start_conv(3, 2, 0);
    c = 0;
    while (init_cnt < 2 && c < 200) begin
      @(posedge clk);
      c++;
    end
    check("midreset_pixel2_reached", 64'(init_cnt), 64'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    reset = 1'b0;
    clear_mon();
    start_conv(3, 2, 0);
    wait_done(400);
    check_seq_a("rerun");
    check("rerun_done_cnt", 64'(done_cnt), 64'd1);

    // Start pulsed while busy is ignored.
    clear_mon();
    start_conv(3, 2, 0);
    repeat (3) @(posedge clk);
    #1;
    n_dim = 8'd2;
    k_dim = 8'd2;
    bias = 16'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
    check_seq_a("busy_start");
    check("busy_start_done_cnt", 64'(done_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
